// File: rtl/decode_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, control-field codes
// and the ID/EX pipeline register layout.
package decode_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } idex_t;

  function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                             input logic [1:0]  imm_src);
    logic [31:0] imm;
    imm = '0;
    case (imm_src)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// 32x32 register file with two combinational read ports and one write port;
// x0 reads as zero. WB_BYPASS_EN forwards the write-back data to same-cycle reads.
module register_file
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_regs [32];
  logic        w_wr_valid;

  assign w_wr_valid = i_we && (i_wa != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 != 5'd0) o_rd1 = r_regs[i_ra1];
    if (i_ra2 != 5'd0) o_rd2 = r_regs[i_ra2];
`ifdef WB_BYPASS_EN
    // w_wr_valid already excludes x0, so the zero rule still holds
    if (w_wr_valid && (i_ra1 == i_wa)) o_rd1 = i_wd;
    if (w_wr_valid && (i_ra2 == i_wa)) o_rd2 = i_wd;
`endif
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: main/ALU decoders, immediate extender and the ID/EX
// register. Optional build macro WB_BYPASS_EN enables write-back read bypass.
module decode_cycle
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  input  logic        StallE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  w_op;
  logic [2:0]  w_funct3;
  logic        w_funct7b5;
  logic        w_reg_write;
  logic        w_mem_write;
  logic        w_jump;
  logic        w_branch;
  logic        w_alu_src;
  logic [1:0]  w_result_src;
  logic [1:0]  w_imm_src;
  logic [1:0]  w_alu_op;
  logic [2:0]  w_alu_control;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  idex_t       w_next;
  idex_t       r_idex;

  assign w_op       = InstrD[6:0];
  assign w_funct3   = InstrD[14:12];
  assign w_funct7b5 = InstrD[30];

  // Unrecognised opcodes fall through with every control bit low (bubble)
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_jump       = 1'b0;
    w_branch     = 1'b0;
    w_alu_src    = 1'b0;
    w_result_src = RES_ALU;
    w_imm_src    = IMM_I;
    w_alu_op     = ALUOP_ADD;
    case (w_op)
      OP_LW: begin
        w_reg_write  = 1'b1;
        w_alu_src    = 1'b1;
        w_result_src = RES_MEM;
        w_imm_src    = IMM_I;
        w_alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        w_mem_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_src   = IMM_S;
        w_alu_op    = ALUOP_ADD;
      end
      OP_RTYPE: begin
        w_reg_write = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
      end
      OP_IALU: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_src   = IMM_I;
        w_alu_op    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        w_branch  = 1'b1;
        w_imm_src = IMM_B;
        w_alu_op  = ALUOP_SUB;
      end
      OP_JAL: begin
        w_reg_write  = 1'b1;
        w_jump       = 1'b1;
        w_result_src = RES_PC4;
        w_imm_src    = IMM_J;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_alu_control = ALUCTL_ADD;
    case (w_alu_op)
      ALUOP_ADD: w_alu_control = ALUCTL_ADD;
      ALUOP_SUB: w_alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (w_funct3)
          3'b000:  w_alu_control = ({w_op[5], w_funct7b5} == 2'b11) ? ALUCTL_SUB
                                                                     : ALUCTL_ADD;
          3'b010:  w_alu_control = ALUCTL_SLT;
          3'b110:  w_alu_control = ALUCTL_OR;
          3'b111:  w_alu_control = ALUCTL_AND;
          default: w_alu_control = ALUCTL_ADD;
        endcase
      end
      default: w_alu_control = ALUCTL_ADD;
    endcase
  end

  register_file u_register_file (
    .clk   (clk),
    .rst   (rst),
    .i_we  (RegWriteW),
    .i_wa  (RdW),
    .i_wd  (ResultW),
    .i_ra1 (InstrD[19:15]),
    .i_ra2 (InstrD[24:20]),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2)
  );

  always_comb begin
    w_next             = '0;
    w_next.reg_write   = w_reg_write;
    w_next.mem_write   = w_mem_write;
    w_next.jump        = w_jump;
    w_next.branch      = w_branch;
    w_next.alu_src     = w_alu_src;
    w_next.result_src  = w_result_src;
    w_next.alu_control = w_alu_control;
    w_next.rd1         = w_rd1;
    w_next.rd2         = w_rd2;
    w_next.imm_ext     = imm_extend(InstrD, w_imm_src);
    w_next.rs1         = InstrD[19:15];
    w_next.rs2         = InstrD[24:20];
    w_next.rd          = InstrD[11:7];
    w_next.pc          = PCD;
    w_next.pc_plus4    = PCPlus4D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idex <= '0;
    end else if (FlushE) begin
      r_idex <= '0;
    end else if (!StallE) begin
      r_idex <= w_next;
    end
  end

  assign RegWriteE   = r_idex.reg_write;
  assign MemWriteE   = r_idex.mem_write;
  assign JumpE       = r_idex.jump;
  assign BranchE     = r_idex.branch;
  assign ALUSrcE     = r_idex.alu_src;
  assign ResultSrcE  = r_idex.result_src;
  assign ALUControlE = r_idex.alu_control;
  assign RD1E        = r_idex.rd1;
  assign RD2E        = r_idex.rd2;
  assign ImmExtE     = r_idex.imm_ext;
  assign Rs1E        = r_idex.rs1;
  assign Rs2E        = r_idex.rs2;
  assign RdE         = r_idex.rd;
  assign PCE         = r_idex.pc;
  assign PCPlus4E    = r_idex.pc_plus4;

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Decode stage of the 5-stage RV32I pipeline. Consumes the IF/ID register outputs (InstrD, PCD, PCPlus4D) and decodes the instruction into control signals. It reads operands from an internal 32x32 register file, written by write-back, and sign-extends the immediate. All results are registered into the ID/EX pipeline register for the execute stage.

## Interface

Parameters:
- none; all widths are fixed at 32-bit datapath and 5-bit register index.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset, asynchronous, active-low.
- InstrD  in  32  instruction from IF/ID.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- RegWriteW  in  1  write-back register write enable.
- RdW  in  5  write-back destination.
- ResultW  in  32  write-back data.
- FlushE  in  1  load a bubble into ID/EX.
- StallE  in  1  hold ID/EX contents.
- RegWriteE  out  1  register write enable.
- MemWriteE  out  1  data memory write enable.
- JumpE  out  1  instruction is jal.
- BranchE  out  1  instruction is beq.
- ALUSrcE  out  1  ALU operand B select: 1 = immediate, 0 = RD2E.
- ResultSrcE  out  2  result select: 00 = ALU, 01 = memory, 10 = PC+4.
- ALUControlE  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- RD1E, RD2E  out  32  register operands.
- ImmExtE  out  32  sign-extended immediate.
- Rs1E, Rs2E, RdE  out  5  register indices, used by the hazard unit.
- PCE, PCPlus4E  out  32  forwarded PC values.

## Operation

- Main decoder, keyed on opcode InstrD[6:0]:
  - lw 0000011 and sw 0100011: ALUOp 00.
  - R-type 0110011 and I-ALU 0010011: ALUOp 10.
  - beq 1100011: ALUOp 01.
  - jal 1101111: ResultSrc 10, ImmSrc J.
- Any other opcode, including 0x00000000: all control signals are 0, giving a bubble. Fields and data are still registered.
- ALU decoder:
  - ALUOp 00 gives add.
  - ALUOp 01 gives sub.
  - ALUOp 10 decodes funct3: 000 gives sub only when {op[5], funct7[5]} = 11, otherwise add. 010 gives slt, 110 gives or, 111 gives and.
  - Any other funct3 gives add.
- ImmSrc encodings: 00 = I {20{i[31]},i[31:20]}; 01 = S {20{i[31]},i[31:25],i[11:7]}; 10 = B {19{i[31]},i[31],i[7],i[30:25],i[11:8],0}; 11 = J {11{i[31]},i[31],i[19:12],i[20],i[30:21],0}.
- Register file:
  - Read ports are combinational on rs1 = i[19:15] and rs2 = i[24:20].
  - Writes happen on posedge clk when RegWriteW is 1 and RdW is not 0.
  - x0 always reads 0.
- Rs1E, Rs2E and RdE carry the raw instruction fields regardless of format.

## Timing

- Latency: 1 cycle. Inputs presented in cycle n appear on the E outputs after posedge n+1.
- Reset (rst = 0) clears every E output and every register-file entry to 0 immediately.
- Priority at each posedge: FlushE over StallE over normal load.
  - FlushE = 1 clears all E outputs to 0 (nop).
  - StallE = 1 leaves all E outputs unchanged.
- Register-file writes are never gated by FlushE or StallE.
- Releasing reset mid-stream: the first decoded instruction is whatever sits on InstrD at the first posedge after release.

## Configuration

- WB_BYPASS_EN defined: a read whose index equals RdW returns ResultW in the same cycle, when RegWriteW = 1 and the index is not 0. A write and read of the same register in one cycle therefore captures the new value into RD1E/RD2E.
- WB_BYPASS_EN undefined: reads return the pre-write value. The hazard unit must then cover that case with a one-cycle stall.

## Structure

- Package decode_pkg holds:
  - opcode constants;
  - ALUOp, ALUControl, ImmSrc and ResultSrc encodings as localparams.
- Sub-module register_file contains the 32x32 array, the x0 rule and the WB_BYPASS_EN logic.
- The main decoder, ALU decoder, immediate extender and ID/EX register are in the top module.

## Test plan

- Reset, then InstrD = 0x00000000: all E outputs read 0, including RegWriteE and MemWriteE.
- InstrD = 0x00500093 (addi x1,x0,5): after one cycle RegWriteE = 1, ALUSrcE = 1, ALUControlE = 000, ImmExtE = 5, RdE = 1, RD1E = 0.
- Write x1 = 0x12345678 via WB (RegWriteW = 1, RdW = 1) in the same cycle that InstrD = 0x0020A423 (sw x2,8(x1)):
  - With WB_BYPASS_EN, RD1E = 0x12345678. Without it, RD1E = 0; repeat the instruction the next cycle and RD1E = 0x12345678.
  - Both builds: MemWriteE = 1 and ImmExtE = 8.
- InstrD = 0xFE208EE3 (beq x1,x2,-4): BranchE = 1, ALUControlE = 001, ImmExtE = 0xFFFFFFFC, Rs1E = 1, Rs2E = 2.
- Write x0 = 0xFFFFFFFF via WB, then decode any instruction reading x0: the register read returns 0.
- StallE = 1 and FlushE = 1 together, with a valid addi present: E outputs become all 0. Next cycle with StallE = 1 only and a new instruction: E outputs stay 0.
